// File: rtl/wimax_mod_pkg.sv
// -----------------------------------------------------------------------------
// wimax_mod_pkg
// Shared types and helpers for the multi-mode constellation mapper.
//   mod_mode_t : modulation selector (BPSK, QPSK, 16-QAM, 64-QAM)
//   bps()      : bits carried by one symbol of a given mode
//   level()    : rounds a real amplitude to a Q2.(w-2) integer at elaboration
// -----------------------------------------------------------------------------
package wimax_mod_pkg;

  typedef enum logic [1:0] {
    BPSK  = 2'd0,
    QPSK  = 2'd1,
    QAM16 = 2'd2,
    QAM64 = 2'd3
  } mod_mode_t;

  // Normalisation factors so every constellation has unit average energy.
  localparam real INV_SQRT2  = 0.70710678118654752;
  localparam real INV_SQRT10 = 0.31622776601683794;
  localparam real INV_SQRT42 = 0.15430334996209191;

  function automatic logic [2:0] bps(input mod_mode_t m);
    case (m)
      BPSK:    return 3'd1;
      QPSK:    return 3'd2;
      QAM16:   return 3'd4;
      default: return 3'd6;
    endcase
  endfunction

  // Only ever called with positive amplitudes, so +0.5 then truncate rounds
  // to nearest.
  function automatic int level(input real x, input int w);
    real scale;
    scale = 1.0;
    for (int k = 0; k < w - 2; k++) scale = scale * 2.0;
    return $rtoi(x * scale + 0.5);
  endfunction

endpackage

// File: rtl/qam_lut.sv
// -----------------------------------------------------------------------------
// qam_lut
// Purely combinational constellation lookup. Bit 0 of the group is the first
// bit received (b0). Sign bits select negative when 1; negative points are the
// exact two's-complement negation of the positive level.
// Ports:
//   mode  in  mod_mode_t  modulation of this group
//   bits  in  6           bit group, b0 in bits[0]; unused bits ignored
//   i_val out W           in-phase sample, Q2.(W-2)
//   q_val out W           quadrature sample, Q2.(W-2)
// -----------------------------------------------------------------------------
module qam_lut
  import wimax_mod_pkg::*;
#(
  parameter int W = 16
) (
  input  mod_mode_t             mode,
  input  logic [5:0]            bits,
  output logic signed [W-1:0]   i_val,
  output logic signed [W-1:0]   q_val
);

  localparam logic signed [W-1:0] L_ONE    = W'(level(1.0, W));
  localparam logic signed [W-1:0] L_QPSK   = W'(level(INV_SQRT2, W));
  localparam logic signed [W-1:0] L16_1    = W'(level(1.0 * INV_SQRT10, W));
  localparam logic signed [W-1:0] L16_3    = W'(level(3.0 * INV_SQRT10, W));
  localparam logic signed [W-1:0] L64_1    = W'(level(1.0 * INV_SQRT42, W));
  localparam logic signed [W-1:0] L64_3    = W'(level(3.0 * INV_SQRT42, W));
  localparam logic signed [W-1:0] L64_5    = W'(level(5.0 * INV_SQRT42, W));
  localparam logic signed [W-1:0] L64_7    = W'(level(7.0 * INV_SQRT42, W));

  function automatic logic signed [W-1:0] apply_sign(input logic neg,
                                                     input logic signed [W-1:0] mag);
    return neg ? -mag : mag;
  endfunction

  // Gray-coded 64-QAM magnitude; g[1] is the earlier-received bit.
  function automatic logic signed [W-1:0] mag64(input logic [1:0] g);
    case (g)
      2'b00:   return L64_1;
      2'b01:   return L64_3;
      2'b11:   return L64_5;
      default: return L64_7;
    endcase
  endfunction

  always_comb begin
    i_val = '0;
    q_val = '0;
    case (mode)
      BPSK: begin
        i_val = apply_sign(bits[0], L_ONE);
      end
      QPSK: begin
        i_val = apply_sign(bits[0], L_QPSK);
        q_val = apply_sign(bits[1], L_QPSK);
      end
      QAM16: begin
        i_val = apply_sign(bits[0], bits[1] ? L16_3 : L16_1);
        q_val = apply_sign(bits[2], bits[3] ? L16_3 : L16_1);
      end
      default: begin
        i_val = apply_sign(bits[0], mag64({bits[1], bits[2]}));
        q_val = apply_sign(bits[3], mag64({bits[4], bits[5]}));
      end
    endcase
  end

endmodule

// File: rtl/qam_mapper.sv
// -----------------------------------------------------------------------------
// qam_mapper
// Serial-bit to I/Q constellation mapper (BPSK/QPSK/16-QAM/64-QAM) with a
// single registered output slot and valid/ready back-pressure.
// Ports:
//   clk_100   in  1  clock, rising edge
//   Reset     in  1  synchronous active-high reset
//   mode_in   in  2  modulation, latched on the first bit of each symbol
//   valid_in  in  1  data_in valid
//   data_in   in  1  serial bit, b0 first
//   ready_out out 1  a bit can be accepted this cycle
//   flush_in  in  1  pad and emit a partially collected symbol
//   partial   out 1  accumulator holds some but not all bits of a symbol
//   valid_out out 1  I_comp/Q_comp hold a symbol
//   ready_in  in  1  downstream takes the symbol this cycle
//   I_comp    out W  in-phase sample, Q2.(W-2)
//   Q_comp    out W  quadrature sample, Q2.(W-2)
// -----------------------------------------------------------------------------
module qam_mapper
  import wimax_mod_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                 clk_100,
  input  logic                 Reset,
  input  logic [1:0]           mode_in,
  input  logic                 valid_in,
  input  logic                 data_in,
  output logic                 ready_out,
  input  logic                 flush_in,
  output logic                 partial,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic signed [W-1:0]  I_comp,
  output logic signed [W-1:0]  Q_comp
);

  logic [2:0]          cnt;
  logic [5:0]          acc;
  mod_mode_t           cur_mode;
  mod_mode_t           eff_mode;
  logic                last;
  logic                accept;
  logic                flush_fire;
  logic                load;
  logic [5:0]          group;
  logic signed [W-1:0] lut_i;
  logic signed [W-1:0] lut_q;

  // On the first bit the symbol's mode is whatever mode_in says now, so a
  // BPSK bit is recognised as last (and may stall) in the same cycle.
  assign eff_mode   = (cnt == 3'd0) ? mod_mode_t'(mode_in) : cur_mode;
  assign last       = (cnt == bps(eff_mode) - 3'd1);
  assign ready_out  = !Reset && (!last || !valid_out || ready_in);
  assign accept     = valid_in && ready_out;
  assign partial    = (cnt != 3'd0);
  assign flush_fire = flush_in && !valid_in && partial && (!valid_out || ready_in);
  assign load       = (accept && last) || flush_fire;

  // acc is cleared after every symbol, so bits above cnt are already the
  // zero padding a flush needs.
  assign group = acc | (accept ? (6'(data_in) << cnt) : 6'd0);

  qam_lut #(.W(W)) u_lut (
    .mode  (eff_mode),
    .bits  (group),
    .i_val (lut_i),
    .q_val (lut_q)
  );

  // Accumulator and output register stage
  always_ff @(posedge clk_100) begin
    if (Reset) begin
      cnt       <= 3'd0;
      acc       <= 6'd0;
      cur_mode  <= QPSK;
      valid_out <= 1'b0;
      I_comp    <= '0;
      Q_comp    <= '0;
    end else begin
      if (accept) begin
        if (cnt == 3'd0) cur_mode <= mod_mode_t'(mode_in);
        if (last) begin
          cnt <= 3'd0;
          acc <= 6'd0;
        end else begin
          cnt <= cnt + 3'd1;
          acc <= group;
        end
      end else if (flush_fire) begin
        cnt <= 3'd0;
        acc <= 6'd0;
      end

      if (load) begin
        valid_out <= 1'b1;
        I_comp    <= lut_i;
        Q_comp    <= lut_q;
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qam_mapper.sv
// -----------------------------------------------------------------------------
// tb_qam_mapper
// Directed bench for qam_mapper. Stimulus pushes hand-computed I/Q pairs into
// a queue; an independent monitor pops and compares on every output transfer.
// -----------------------------------------------------------------------------
module tb_qam_mapper;

  logic               clk_100 = 1'b0;
  logic               Reset;
  logic [1:0]         mode_in;
  logic               valid_in;
  logic               data_in;
  logic               ready_out;
  logic               flush_in;
  logic               partial;
  logic               valid_out;
  logic               ready_in;
  logic signed [15:0] I_comp;
  logic signed [15:0] Q_comp;

  always #5 clk_100 = ~clk_100;

  qam_mapper #(.W(16)) dut (
    .clk_100   (clk_100),
    .Reset     (Reset),
    .mode_in   (mode_in),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .flush_in  (flush_in),
    .partial   (partial),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .I_comp    (I_comp),
    .Q_comp    (Q_comp)
  );

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } sym_t;

  sym_t exp_q[$];
  sym_t mon_exp;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_pop    = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] i, input logic [15:0] q);
    exp_q.push_back({i, q});
    n_push++;
  endtask

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  // Presents one bit and returns just after the edge that accepted it.
  // valid_in is left high so consecutive calls stream one bit per cycle.
  task automatic send_bit(input logic b, input logic [1:0] m);
    int waited;
    waited   = 0;
    valid_in = 1'b1;
    data_in  = b;
    mode_in  = m;
    @(negedge clk_100);
    while (!ready_out && waited < 50) begin
      waited++;
      @(negedge clk_100);
    end
    if (!ready_out) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_bit_timeout: ready_out stayed 0 for %0d cycles", waited);
    end
    step();
  endtask

  task automatic idle();
    valid_in = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk_100);
      if (!Reset && valid_out && ready_in) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_symbol: got I=0x%0h Q=0x%0h, no symbol expected",
                   I_comp, Q_comp);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sym_I", I_comp, mon_exp.i);
          check("sym_Q", Q_comp, mon_exp.q);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    Reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 1'b0;
    mode_in  = 2'd0;
    flush_in = 1'b0;
    ready_in = 1'b1;

    // Reset state
    repeat (3) @(posedge clk_100);
    @(negedge clk_100);
    check("rst_valid_out", valid_out, 0);
    check("rst_ready_out", ready_out, 0);
    check("rst_partial",   partial,   0);
    check("rst_I",         I_comp,    16'h0000);
    check("rst_Q",         Q_comp,    16'h0000);
    step();
    Reset = 1'b0;
    @(negedge clk_100);
    check("post_rst_ready", ready_out, 1);

    // QPSK 0,1 with one-cycle latency
    step();
    push_exp(16'h2D41, 16'hD2BF);
    send_bit(1'b0, 2'd1);
    send_bit(1'b1, 2'd1);
    check("qpsk_latency_valid", valid_out, 1);
    check("qpsk_latency_I",     I_comp,    16'h2D41);
    idle();

    // 64-QAM: -5/+7, then -7/+7 with mode_in changed mid-symbol
    step();
    push_exp(16'hCE9F, 16'h4521);
    send_bit(1'b1, 2'd3); send_bit(1'b1, 2'd3); send_bit(1'b1, 2'd3);
    send_bit(1'b0, 2'd3); send_bit(1'b1, 2'd3); send_bit(1'b0, 2'd3);
    push_exp(16'hBADF, 16'h4521);
    send_bit(1'b1, 2'd3); send_bit(1'b1, 2'd0); send_bit(1'b0, 2'd0);
    send_bit(1'b0, 2'd0); send_bit(1'b1, 2'd0); send_bit(1'b0, 2'd0);
    idle();

    // BPSK 0,1,0 back to back: one symbol per cycle
    step();
    push_exp(16'h4000, 16'h0000);
    push_exp(16'hC000, 16'h0000);
    push_exp(16'h4000, 16'h0000);
    send_bit(1'b0, 2'd0);
    check("bpsk_valid0", valid_out, 1);
    send_bit(1'b1, 2'd0);
    check("bpsk_valid1", valid_out, 1);
    send_bit(1'b0, 2'd0);
    check("bpsk_valid2", valid_out, 1);
    idle();

    // 16-QAM back-pressure: symbol 1 held, last bit of symbol 2 stalls
    step();
    ready_in = 1'b0;
    push_exp(16'h3CB7, 16'hEBC3);
    send_bit(1'b0, 2'd2); send_bit(1'b1, 2'd2); send_bit(1'b1, 2'd2); send_bit(1'b0, 2'd2);
    push_exp(16'hEBC3, 16'h3CB7);
    send_bit(1'b1, 2'd2); send_bit(1'b0, 2'd2); send_bit(1'b0, 2'd2);
    valid_in = 1'b1;
    data_in  = 1'b1;
    @(negedge clk_100);
    check("bp_ready_low",  ready_out, 0);
    check("bp_hold_I",     I_comp,    16'h3CB7);
    step();
    @(negedge clk_100);
    check("bp_still_low",  ready_out, 0);
    check("bp_stable_I",   I_comp,    16'h3CB7);
    check("bp_stable_Q",   Q_comp,    16'hEBC3);
    step();
    ready_in = 1'b1;
    @(negedge clk_100);
    check("bp_ready_high", ready_out, 1);
    step();
    check("bp_reload_valid", valid_out, 1);
    check("bp_reload_I",     I_comp,    16'hEBC3);
    idle();

    // 16-QAM flush after two bits
    step();
    push_exp(16'hC349, 16'h143D);
    send_bit(1'b1, 2'd2);
    send_bit(1'b1, 2'd2);
    idle();
    @(negedge clk_100);
    check("flush_partial_set", partial,   1);
    step();
    check("flush_pre_valid",   valid_out, 0);
    flush_in = 1'b1;
    w = 0;
    @(negedge clk_100);
    while (partial && w < 20) begin
      w++;
      @(negedge clk_100);
    end
    check("flush_partial_clear", partial,   0);
    check("flush_valid",         valid_out, 1);
    // flush_in still high with nothing partial: must be a no-op
    repeat (3) step();
    @(negedge clk_100);
    check("flush_noop_valid",   valid_out, 0);
    check("flush_noop_partial", partial,   0);
    step();
    flush_in = 1'b0;

    // Reset with a held symbol and 3 of 6 bits collected
    ready_in = 1'b0;
    send_bit(1'b1, 2'd1); send_bit(1'b1, 2'd1);
    send_bit(1'b0, 2'd3); send_bit(1'b1, 2'd3); send_bit(1'b0, 2'd3);
    idle();
    @(negedge clk_100);
    check("mid_partial",   partial,   1);
    check("mid_valid",     valid_out, 1);
    step();
    Reset = 1'b1;
    @(negedge clk_100);
    check("mid_rst_ready", ready_out, 0);
    step();
    Reset = 1'b0;
    @(negedge clk_100);
    check("mid_rst_valid",   valid_out, 0);
    check("mid_rst_partial", partial,   0);
    check("mid_rst_I",       I_comp,    16'h0000);
    check("mid_rst_Q",       Q_comp,    16'h0000);
    step();
    ready_in = 1'b1;
    push_exp(16'hD2BF, 16'h2D41);
    send_bit(1'b1, 2'd1);
    send_bit(1'b0, 2'd1);
    check("after_rst_valid", valid_out, 1);
    idle();

    // Drain and account for every expected symbol
    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      w++;
      @(negedge clk_100);
    end
    repeat (2) @(negedge clk_100);
    check("queue_empty", 16'(exp_q.size()), 16'd0);
    check("pop_count",   16'(n_pop),        16'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
